// File: rtl/cgra_csr_pkg.sv
// Shared definitions for the multi-channel CGRA CSR block: register offsets,
// channel window layout, IRQ bit positions and the DMA descriptor type.
package cgra_csr_pkg;

    // Global register offsets (paddr[9:0])
    localparam logic [9:0] CU_CTRL_OFF    = 10'h000;
    localparam logic [9:0] CU_STATUS_OFF  = 10'h004;
    localparam logic [9:0] CU_CYCLES_OFF  = 10'h008;
    localparam logic [9:0] CU_TIMEOUT_OFF = 10'h00C;
    localparam logic [9:0] IRQ_STATUS_OFF = 10'h010;
    localparam logic [9:0] IRQ_MASK_OFF   = 10'h014;
    localparam logic [9:0] ID_OFF         = 10'h018;

    // Channel window: base 0x100, stride 0x20, index in paddr[7:5]
    localparam logic [9:0] CH_BASE    = 10'h100;
    localparam int         CH_STRIDE  = 32;
    localparam int         CH_IDX_LSB = 5;

    // Channel register offsets inside one channel window
    localparam logic [4:0] CH_CTRL_OFF     = 5'h00;
    localparam logic [4:0] CH_STATUS_OFF   = 5'h04;
    localparam logic [4:0] CH_SRC_OFF      = 5'h08;
    localparam logic [4:0] CH_DST_OFF      = 5'h0C;
    localparam logic [4:0] CH_SIZE_OFF     = 5'h10;
    localparam logic [4:0] CH_DONE_CNT_OFF = 5'h14;

    // IRQ_STATUS bit positions
    localparam int IRQ_CH_DONE_LSB = 0;
    localparam int IRQ_CU_DONE_BIT = 8;
    localparam int IRQ_CH_OVF_LSB  = 16;

    localparam logic [15:0] ID_MAGIC = 16'hC6A2;
    localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] size;
    } dma_desc_t;

endpackage

// File: rtl/cgra_desc_fifo.sv
// Synchronous descriptor FIFO, one per DMA channel. Full is judged before a
// same-cycle pop, so a push into a full queue is dropped even if the head
// leaves in the same cycle. Flush has priority over push and pop.
module cgra_desc_fifo
    import cgra_csr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  dma_desc_t                din,
    output dma_desc_t                dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    dma_desc_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer, occupancy and storage update; reset and flush empty the queue
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/cgra_apb_csr_mc.sv
// Multi-channel APB CSR block for the CGRA subsystem: Control Unit registers,
// W1C interrupt status/mask, and NUM_CH DMA descriptor queues with staging
// registers and done counters. Optional macro CGRA_CSR_TIMEOUT_EN makes
// CU_TIMEOUT a real register driving cu_max_cycles.
//
// Descriptor handshake: dma_desc_valid[c] is high whenever channel c's queue
// is non-empty and the head descriptor is on the outputs; it is transferred
// (popped) on a rising edge where valid and dma_desc_ready[c] are both high.
// valid never depends on ready, and the head stays stable until popped or
// the queue is flushed/reset.
module cgra_apb_csr_mc
    import cgra_csr_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int QUEUE_DEPTH = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic [NUM_CH-1:0]       dma_desc_valid,
    input  logic [NUM_CH-1:0]       dma_desc_ready,
    output logic [NUM_CH*32-1:0]    dma_desc_src,
    output logic [NUM_CH*32-1:0]    dma_desc_dst,
    output logic [NUM_CH*32-1:0]    dma_desc_size,
    input  logic [NUM_CH-1:0]       dma_busy_i,
    input  logic [NUM_CH-1:0]       dma_done_i,
    output logic                    cu_start,
    output logic                    cu_soft_reset,
    output logic [31:0]             cu_max_cycles,
    input  logic                    cu_busy_i,
    input  logic                    cu_done_i,
    input  logic [31:0]             cu_cycles_i,
    output logic                    irq
);

    localparam int LVW = $clog2(QUEUE_DEPTH) + 1;

    // APB decode
    logic        access;
    logic        wr;
    logic [9:0]  addr;
    logic [2:0]  ch_idx;
    logic [4:0]  ch_off;
    logic        glb_region;
    logic        ch_region;
    logic        addr_ok;
    logic [31:0] rd_data;
    logic        unused_bits;

    // Control Unit state
    logic        cu_start_q;
    logic        cu_soft_reset_q;
    logic        cu_done_latch;
    logic [31:0] cu_timeout_q;

    // Interrupts
    logic [31:0] irq_status;
    logic [31:0] irq_mask;
    logic [31:0] irq_set;
    logic [31:0] irq_clr;
    logic [31:0] irq_impl;
    logic        irq_q;

    // Per-channel state
    logic [31:0] src_q      [NUM_CH];
    logic [31:0] dst_q      [NUM_CH];
    logic [31:0] size_q     [NUM_CH];
    logic [31:0] done_cnt   [NUM_CH];
    logic [31:0] ch_status  [NUM_CH];
    logic [LVW-1:0] fifo_level [NUM_CH];
    dma_desc_t   head       [NUM_CH];
    logic [NUM_CH-1:0] ch_sel_wr;
    logic [NUM_CH-1:0] ctrl_wr;
    logic [NUM_CH-1:0] q_push;
    logic [NUM_CH-1:0] q_flush;
    logic [NUM_CH-1:0] q_pop;
    logic [NUM_CH-1:0] q_full;
    logic [NUM_CH-1:0] q_empty;
    logic [NUM_CH-1:0] ovf_set;

    assign access      = psel && penable;
    assign wr          = access && pwrite;
    assign addr        = paddr[9:0];
    assign ch_idx      = addr[CH_IDX_LSB +: 3];
    assign ch_off      = addr[4:0];
    assign glb_region  = (addr[9:8] == 2'b00);
    assign ch_region   = (addr[9:8] == CH_BASE[9:8]);
    assign unused_bits = ^paddr[ADDR_WIDTH-1:10];

    assign pready        = 1'b1;
    assign cu_start      = cu_start_q;
    assign cu_soft_reset = cu_soft_reset_q;
    assign irq           = irq_q;

`ifdef CGRA_CSR_TIMEOUT_EN
    assign cu_max_cycles = cu_timeout_q;
`else
    assign cu_max_cycles = 32'd0;
`endif

    // Per-channel queue wiring, push/flush decode and status word
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dma_desc_t stage;

        assign ch_sel_wr[g] = wr && ch_region && (ch_idx == 3'(g));
        assign ctrl_wr[g]   = ch_sel_wr[g] && (ch_off == CH_CTRL_OFF);
        assign q_flush[g]   = ctrl_wr[g] && pwdata[1];
        assign q_push[g]    = ctrl_wr[g] && pwdata[0] && !pwdata[1];
        assign ovf_set[g]   = q_push[g] && q_full[g];
        assign q_pop[g]     = !q_empty[g] && dma_desc_ready[g];

        assign stage.src  = src_q[g];
        assign stage.dst  = dst_q[g];
        assign stage.size = size_q[g];

        cgra_desc_fifo #(
            .DEPTH (QUEUE_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (q_push[g]),
            .pop   (q_pop[g]),
            .flush (q_flush[g]),
            .din   (stage),
            .dout  (head[g]),
            .full  (q_full[g]),
            .empty (q_empty[g]),
            .level (fifo_level[g])
        );

        assign dma_desc_valid[g]         = !q_empty[g];
        assign dma_desc_src[32*g +: 32]  = head[g].src;
        assign dma_desc_dst[32*g +: 32]  = head[g].dst;
        assign dma_desc_size[32*g +: 32] = head[g].size;

        // STATUS word: busy, valid, full, empty, level, overflow
        always_comb begin
            ch_status[g]          = '0;
            ch_status[g][0]       = dma_busy_i[g];
            ch_status[g][1]       = !q_empty[g];
            ch_status[g][2]       = q_full[g];
            ch_status[g][3]       = q_empty[g];
            ch_status[g][8 +: LVW] = fifo_level[g];
            ch_status[g][16]      = irq_status[IRQ_CH_OVF_LSB + g];
        end
    end

    // Read mux and address validity for the current access
    always_comb begin
        rd_data = BAD_DATA;
        addr_ok = 1'b0;
        if (glb_region) begin
            addr_ok = 1'b1;
            case (addr)
                CU_CTRL_OFF:    rd_data = {30'd0, cu_soft_reset_q, 1'b0};
                CU_STATUS_OFF:  rd_data = {30'd0, cu_done_latch, cu_busy_i};
                CU_CYCLES_OFF:  rd_data = cu_cycles_i;
`ifdef CGRA_CSR_TIMEOUT_EN
                CU_TIMEOUT_OFF: rd_data = cu_timeout_q;
`else
                CU_TIMEOUT_OFF: rd_data = 32'd0;
`endif
                IRQ_STATUS_OFF: rd_data = irq_status;
                IRQ_MASK_OFF:   rd_data = irq_mask;
                ID_OFF:         rd_data = {ID_MAGIC, 8'(QUEUE_DEPTH), 8'(NUM_CH)};
                default: begin
                    rd_data = BAD_DATA;
                    addr_ok = 1'b0;
                end
            endcase
        end else if (ch_region) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_idx == 3'(c)) begin
                    addr_ok = 1'b1;
                    case (ch_off)
                        CH_CTRL_OFF:     rd_data = 32'd0;
                        CH_STATUS_OFF:   rd_data = ch_status[c];
                        CH_SRC_OFF:      rd_data = src_q[c];
                        CH_DST_OFF:      rd_data = dst_q[c];
                        CH_SIZE_OFF:     rd_data = size_q[c];
                        CH_DONE_CNT_OFF: rd_data = done_cnt[c];
                        default: begin
                            rd_data = BAD_DATA;
                            addr_ok = 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // APB response: data only on reads, error on bad address or queue overflow
    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        if (access) begin
            pslverr = !addr_ok || (pwrite && (|ovf_set)) || unused_bits & 1'b0;
            if (!pwrite) begin
                prdata = rd_data;
            end
        end
    end

    // IRQ set/clear sources and the mask of implemented status bits
    always_comb begin
        irq_set  = '0;
        irq_impl = '0;
        irq_set[IRQ_CU_DONE_BIT]  = cu_done_i;
        irq_impl[IRQ_CU_DONE_BIT] = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            irq_set[IRQ_CH_DONE_LSB + c]  = dma_done_i[c];
            irq_set[IRQ_CH_OVF_LSB + c]   = ovf_set[c];
            irq_impl[IRQ_CH_DONE_LSB + c] = 1'b1;
            irq_impl[IRQ_CH_OVF_LSB + c]  = 1'b1;
        end
        irq_clr = (wr && glb_region && addr == IRQ_STATUS_OFF) ? pwdata : '0;
    end

    // Global registers: CU control, done latch, timeout, IRQ status/mask, irq
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cu_start_q      <= 1'b0;
            cu_soft_reset_q <= 1'b0;
            cu_done_latch   <= 1'b0;
            cu_timeout_q    <= '0;
            irq_status      <= '0;
            irq_mask        <= '0;
            irq_q           <= 1'b0;
        end else begin
            cu_start_q <= wr && glb_region && (addr == CU_CTRL_OFF) && pwdata[0];
            if (wr && glb_region && addr == CU_CTRL_OFF) begin
                cu_soft_reset_q <= pwdata[1];
            end
            if (cu_done_i) begin
                cu_done_latch <= 1'b1;
            end else if (cu_start_q) begin
                cu_done_latch <= 1'b0;
            end
`ifdef CGRA_CSR_TIMEOUT_EN
            if (wr && glb_region && addr == CU_TIMEOUT_OFF) begin
                cu_timeout_q <= pwdata;
            end
`endif
            if (wr && glb_region && addr == IRQ_MASK_OFF) begin
                irq_mask <= pwdata;
            end
            irq_status <= ((irq_status & ~irq_clr) | irq_set) & irq_impl;
            irq_q      <= |(irq_status & irq_mask);
        end
    end

    // Per-channel staging registers and done counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                src_q[c]    <= '0;
                dst_q[c]    <= '0;
                size_q[c]   <= '0;
                done_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_sel_wr[c] && ch_off == CH_SRC_OFF) begin
                    src_q[c] <= pwdata;
                end
                if (ch_sel_wr[c] && ch_off == CH_DST_OFF) begin
                    dst_q[c] <= pwdata;
                end
                if (ch_sel_wr[c] && ch_off == CH_SIZE_OFF) begin
                    size_q[c] <= pwdata;
                end
                if (ch_sel_wr[c] && ch_off == CH_DONE_CNT_OFF) begin
                    done_cnt[c] <= {31'd0, dma_done_i[c]};
                end else if (dma_done_i[c]) begin
                    done_cnt[c] <= done_cnt[c] + 32'd1;
                end
            end
        end
    end

endmodule
